instr_fetch: RTL and testbench

Instruction fetch unit for the RV32I core: owns the program counter and the request/ready handshake to instruction memory. It presents the fetched word and its decoded fields (op, f3, f7) to the control unit. It consumes the control unit's resolved `branch` (already ANDed with zero) and `jump` to select the next PC. It sits between instruction memory and the control unit/datapath, and is the producer end of the decoder's instruction interface.

---
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, runs the request/ready handshake to
// instruction memory, holds the fetched word for the control unit and picks
// the next PC from the resolved branch/jump when the datapath retires.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [2:0]  f3,
  output logic        f7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [1:0] {S_REQ, S_VALID, S_FAULT} state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  fcode_q, fcode_d;
  logic [31:0] next_pc;
  logic [7:0]  cnt_inc;

  assign pc_plus4 = pc_q + 32'd4;
  // branch and jump both redirect to target, so a plain OR selects it
  assign next_pc  = (branch | jump) ? target : pc_plus4;
  assign cnt_inc  = cnt_q + 8'd1;

  // Next-state logic for the fetch FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    fcode_d = fcode_q;
    case (state_q)
      S_REQ: begin
        if (imem_ready) begin
          // a ready on the last allowed edge still wins over the timeout
          instr_d = imem_rdata;
          state_d = S_VALID;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_CNT) begin
            state_d = S_FAULT;
            fcode_d = 2'b01;
          end
        end
      end
      S_VALID: begin
        if (retire) begin
          if (next_pc[1:0] != 2'b00) begin
            // pc keeps the address of the offending instruction
            state_d = S_FAULT;
            fcode_d = 2'b10;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
            cnt_d   = 8'd0;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 8'd0;
      fcode_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      fcode_q <= fcode_d;
    end
  end

  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_VALID);
  assign fault       = (state_q == S_FAULT);
  assign fault_code  = fcode_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign op          = instr_q[6:0];
  assign f3          = instr_q[14:12];
  assign f7          = instr_q[30];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: table of fetch/retire steps with a scoreboard of
// expected held instructions, plus sequences for fault, timeout and reset.
module tb_instr_fetch;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        f7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        retire;
  logic        branch;
  logic        jump;
  logic [31:0] target;
  logic        fault;
  logic [1:0]  fault_code;

  instr_fetch #(.RESET_PC(32'h0), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .f3(f3), .f7(f7),
    .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .retire(retire), .branch(branch), .jump(jump), .target(target),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cyc;
    int          hold_cyc;
    logic [31:0] rdata;
    logic        br;
    logic        jp;
    logic [31:0] tgt;
    logic [31:0] nxt;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_f7;
    logic        e_flt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
  } sb_t;

  vec_t        vecs[9];
  sb_t         sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mpc;
  logic [31:0] last_instr;
  logic        prev_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare each newly presented instruction
  always @(negedge clk) begin
    if (instr_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_pc",    pc,               e.pc);
        chk("sb_instr", instr,            e.instr);
        chk("sb_op",    {25'd0, op},      {25'd0, e.op});
        chk("sb_f3",    {29'd0, f3},      {29'd0, e.f3});
        chk("sb_f7",    {31'd0, f7},      {31'd0, e.f7});
        chk("sb_pc4",   pc_plus4,         e.pc + 32'd4);
      end
    end
    prev_v = instr_valid;
  end

  // One reset edge; returns in the first REQ cycle with rst_n released
  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; retire = 1'b0;
    branch = 1'b0; jump = 1'b0; target = 32'h0; imem_rdata = 32'h0;
    @(negedge clk);
    sb.delete();
    chk("rst_addr",  imem_addr,              32'h0);
    chk("rst_instr", instr,                  32'h0);
    chk("rst_req",   {31'd0, imem_req},      32'd1);
    chk("rst_valid", {31'd0, instr_valid},   32'd0);
    chk("rst_fault", {31'd0, fault},         32'd0);
    chk("rst_code",  {30'd0, fault_code},    32'd0);
    rst_n = 1'b1;
    mpc = 32'h0;
    last_instr = 32'h0;
  endtask

  // Fetch one word with wait states, optionally idle in VALID, then retire
  task automatic do_fetch(input vec_t v);
    for (int i = 0; i <= v.wait_cyc; i++) begin
      chk("req_hi",   {31'd0, imem_req}, 32'd1);
      chk("req_addr", imem_addr,         mpc);
      chk("req_hold", instr,             last_instr);
      imem_ready = (i == v.wait_cyc);
      imem_rdata = (i == v.wait_cyc) ? v.rdata : 32'hDEAD_BEEF;
      if (i == v.wait_cyc) sb.push_back('{mpc, v.rdata, v.e_op, v.e_f3, v.e_f7});
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    chk("val_hi",  {31'd0, instr_valid}, 32'd1);
    chk("val_req", {31'd0, imem_req},    32'd0);
    // redirect inputs without retire must be ignored
    for (int i = 0; i < v.hold_cyc; i++) begin
      branch = 1'b1; jump = 1'b1; target = 32'h0000_0003;
      @(negedge clk);
      chk("hold_val",  {31'd0, instr_valid}, 32'd1);
      chk("hold_addr", imem_addr,            mpc);
      chk("hold_inst", instr,                v.rdata);
    end
    retire = 1'b1; branch = v.br; jump = v.jp; target = v.tgt;
    @(negedge clk);
    retire = 1'b0; branch = 1'b0; jump = 1'b0; target = 32'h0;
    last_instr = v.rdata;
    if (v.e_flt) begin
      chk("mis_fault", {31'd0, fault},       32'd1);
      chk("mis_code",  {30'd0, fault_code},  32'd2);
      chk("mis_pc",    imem_addr,            mpc);
      chk("mis_req",   {31'd0, imem_req},    32'd0);
      chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    end else begin
      chk("nxt_addr",  imem_addr,            v.nxt);
      chk("nxt_req",   {31'd0, imem_req},    32'd1);
      chk("nxt_fault", {31'd0, fault},       32'd0);
      mpc = v.nxt;
    end
  endtask

  initial begin
    //          wait hold rdata          br    jp    tgt            next           op     f3    f7    flt
    vecs[0] = '{0,  1, 32'h0050_0093, 1'b0, 1'b0, 32'h0,        32'h4,         7'h13, 3'd0, 1'b0, 1'b0};
    vecs[1] = '{0,  0, 32'h0010_8113, 1'b0, 1'b0, 32'h0,        32'h8,         7'h13, 3'd0, 1'b0, 1'b0};
    vecs[2] = '{3,  0, 32'h4000_0033, 1'b0, 1'b1, 32'h40,       32'h40,        7'h33, 3'd0, 1'b1, 1'b0};
    vecs[3] = '{0,  0, 32'h0000_0063, 1'b1, 1'b0, 32'h20,       32'h20,        7'h63, 3'd0, 1'b0, 1'b0};
    vecs[4] = '{TO-1, 0, 32'h0000_2003, 1'b0, 1'b1, 32'h40,     32'h40,        7'h03, 3'd2, 1'b0, 1'b0};
    vecs[5] = '{0,  2, 32'h0000_506F, 1'b0, 1'b0, 32'h0,        32'h44,        7'h6F, 3'd5, 1'b0, 1'b0};
    vecs[6] = '{0,  0, 32'h0000_7013, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 7'h13, 3'd7, 1'b0, 1'b0};
    vecs[7] = '{1,  0, 32'h4000_5013, 1'b0, 1'b0, 32'h0,        32'h0,         7'h13, 3'd5, 1'b1, 1'b0};
    vecs[8] = '{0,  0, 32'h0050_0093, 1'b0, 1'b1, 32'h102,      32'h0,         7'h13, 3'd0, 1'b0, 1'b1};

    do_reset();
    for (int k = 0; k < 9; k++) do_fetch(vecs[k]);

    // FAULT ignores every input
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
      retire = 1'b1; jump = 1'b1; target = 32'h80;
      @(negedge clk);
      chk("flt_stay",  {31'd0, fault},       32'd1);
      chk("flt_code",  {30'd0, fault_code},  32'd2);
      chk("flt_req",   {31'd0, imem_req},    32'd0);
      chk("flt_valid", {31'd0, instr_valid}, 32'd0);
      chk("flt_addr",  imem_addr,            32'h0);
    end

    // reset out of FAULT, then reset again mid-REQ at pc=4
    do_reset();
    do_fetch(vecs[0]);
    chk("midreq_pc", imem_addr, 32'h4);
    do_reset();

    // timeout: ready never asserted
    for (int k = 0; k <= TO; k++) begin
      if (k > 0) @(negedge clk);
      chk("to_fault", {31'd0, fault}, (k == TO) ? 32'd1 : 32'd0);
      chk("to_addr",  imem_addr,      32'h0);
    end
    chk("to_code", {30'd0, fault_code}, 32'd1);
    chk("to_req",  {31'd0, imem_req},   32'd0);
    do_reset();
    @(negedge clk);
    chk("post_fault", {31'd0, fault}, 32'd0);
    chk("sb_empty",   sb.size(),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
